// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer
// 512-byte host sector buffer sitting in front of sd_card_controller. The host
// fills or reads the RAM while idle, then requests a sector read or write; the
// block drives the controller handshake and streams one sector between RAM and
// card, flagging short/long sectors and stalled controllers as errors.
//
// Optional feature: define SD_SECTOR_BUF_CRC16_EN to compute CRC16-CCITT
// (poly 0x1021, init 0x0000, MSB first) over the bytes of each completed
// transfer; without it crc_out is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a host request, host owns the RAM
// PREFETCH | write op: load RAM[0] into the outgoing byte register
// LAUNCH   | one-cycle execute pulse to the controller
// XFER     | stream bytes on finished_byte edges, watch for sector end/timeout
// DONE     | one-cycle done pulse, latch CRC
// ERR      | short/long sector or timeout, error raised (sticky)

module sd_sector_buffer #(
  parameter int SECTOR_BYTES   = 512,
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [25:0]       req_sector,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  input  logic              host_we,
  output logic [7:0]        host_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       crc_out,
  output logic              ctrl_op_code,
  output logic              ctrl_execute,
  output logic [25:0]       ctrl_sector_address,
  output logic [7:0]        ctrl_outgoing_byte,
  input  logic [7:0]        ctrl_incoming_byte,
  input  logic              ctrl_finished_byte,
  input  logic              ctrl_finished_sector,
  input  logic              ctrl_busy
);

  localparam int CNT_W = $clog2(SECTOR_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_LAUNCH,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        ram [SECTOR_BYTES];
  logic [7:0]        host_rdata_q;

  logic              fb_s_q, fb_p_q;
  logic              fs_s_q, fs_p_q;
  logic [7:0]        inc_q;
  logic              fb_edge, fs_edge;

  logic              op_q;
  logic [25:0]       sector_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic              over_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [7:0]        out_q;
  logic              error_q;

  logic              accept;
  logic              in_xfer;
  logic              byte_room;
  logic              byte_take;
  logic              byte_over;
  logic [CNT_W-1:0]  cnt_after;
  logic              over_after;
  logic [ADDR_W-1:0] addr_next;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;

  // Progress is tracked purely through the finished_* edges, so the
  // controller's own busy flag carries no extra information here.
  logic              ctrl_busy_unused;
  assign ctrl_busy_unused = ctrl_busy;

  assign accept    = (state_q == S_IDLE) && (req_read || req_write);
  assign in_xfer   = (state_q == S_XFER);
  assign fb_edge   = fb_s_q & ~fb_p_q;
  assign fs_edge   = fs_s_q & ~fs_p_q;
  assign byte_room = (byte_cnt_q != CNT_FULL);
  assign byte_take = in_xfer && fb_edge && byte_room;
  assign byte_over = in_xfer && fb_edge && !byte_room;
  // A byte edge arriving together with the sector edge is counted before the
  // length check, hence the compare works on the post-increment values.
  assign cnt_after  = byte_cnt_q + {{(CNT_W-1){1'b0}}, byte_take};
  assign over_after = over_q | byte_over;
  assign addr_next  = byte_cnt_q[ADDR_W-1:0] + ADDR_W'(1);

  // Register the controller handshake levels once and keep the previous value
  // for rising-edge detection; incoming data is aligned with the byte strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_s_q <= 1'b0;
      fb_p_q <= 1'b0;
      fs_s_q <= 1'b0;
      fs_p_q <= 1'b0;
      inc_q  <= 8'h00;
    end else begin
      fb_s_q <= ctrl_finished_byte;
      fb_p_q <= fb_s_q;
      fs_s_q <= ctrl_finished_sector;
      fs_p_q <= fs_s_q;
      inc_q  <= ctrl_incoming_byte;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; write requests win over simultaneous read requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_write ? S_PREFETCH : S_LAUNCH;
        end
      end
      S_PREFETCH: state_d = S_LAUNCH;
      S_LAUNCH:   state_d = S_XFER;
      S_XFER: begin
        if (fs_edge) begin
          state_d = (cnt_after == CNT_FULL && !over_after) ? S_DONE : S_ERR;
        end else if (!fb_edge && tmr_q == '0) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer datapath: request latching, byte counting, outgoing byte fetch,
  // stall timer and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 1'b0;
      sector_q   <= 26'd0;
      byte_cnt_q <= '0;
      over_q     <= 1'b0;
      tmr_q      <= TMR_LOAD;
      out_q      <= 8'h00;
      error_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= req_write;
        sector_q   <= req_sector;
        byte_cnt_q <= '0;
        over_q     <= 1'b0;
        error_q    <= 1'b0;
      end

      if (state_q == S_PREFETCH) begin
        out_q <= ram[0];
      end

      if (state_q == S_LAUNCH) begin
        tmr_q <= TMR_LOAD;
      end else if (in_xfer) begin
        if (fb_edge || fs_edge) begin
          tmr_q <= TMR_LOAD;
        end else if (tmr_q != '0) begin
          tmr_q <= tmr_q - TMR_W'(1);
        end
      end

      if (byte_take) begin
        byte_cnt_q <= cnt_after;
        if (op_q) begin
          out_q <= ram[addr_next];
        end
      end

      if (byte_over) begin
        over_q <= 1'b1;
      end

      if (in_xfer && state_d == S_ERR) begin
        error_q <= 1'b1;
      end
    end
  end

  // Single RAM write port: host owns it while idle, the transfer while busy.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = host_addr;
    ram_wdata = host_wdata;
    if (byte_take && !op_q) begin
      ram_we    = 1'b1;
      ram_waddr = byte_cnt_q[ADDR_W-1:0];
      ram_wdata = inc_q;
    end else if (!busy && host_we) begin
      ram_we = 1'b1;
    end
  end

  // Buffer RAM, not reset; host read port has one cycle of latency.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
    host_rdata_q <= ram[host_addr];
  end

`ifdef SD_SECTOR_BUF_CRC16_EN
  logic [15:0] crc_run_q;
  logic [15:0] crc_out_q;
  logic [7:0]  crc_byte;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // The byte being transferred is the outgoing register on writes and the
  // aligned incoming byte on reads.
  assign crc_byte = op_q ? out_q : inc_q;

  // Running CRC over accepted bytes; published only on a clean sector end.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_run_q <= 16'h0000;
      crc_out_q <= 16'h0000;
    end else begin
      if (accept) begin
        crc_run_q <= 16'h0000;
      end else if (byte_take) begin
        crc_run_q <= crc16_byte(crc_run_q, crc_byte);
      end
      if (state_q == S_DONE) begin
        crc_out_q <= crc_run_q;
      end
    end
  end

  assign crc_out = crc_out_q;
`else
  assign crc_out = 16'h0000;
`endif

  assign host_rdata          = host_rdata_q;
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign error               = error_q;
  assign ctrl_op_code        = op_q;
  assign ctrl_execute        = (state_q == S_LAUNCH);
  assign ctrl_sector_address = sector_q;
  assign ctrl_outgoing_byte  = out_q;

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Bench for sd_sector_buffer: a byte-array model of the buffer RAM, a
// behavioural controller driving the finished_* handshakes, and a compare
// process checking host reads against the model every cycle they are valid.
// Build with SD_SECTOR_BUF_CRC16_EN defined to exercise the CRC feature.

module tb_sd_sector_buffer;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [25:0] req_sector = 26'd0;
  logic [8:0]  host_addr = 9'd0;
  logic [7:0]  host_wdata = 8'h00;
  logic        host_we = 1'b0;
  logic [7:0]  host_rdata;
  logic        busy, done, error;
  logic [15:0] crc_out;
  logic        ctrl_op_code, ctrl_execute;
  logic [25:0] ctrl_sector_address;
  logic [7:0]  ctrl_outgoing_byte;
  logic [7:0]  ctrl_incoming_byte = 8'h00;
  logic        ctrl_finished_byte = 1'b0;
  logic        ctrl_finished_sector = 1'b0;
  logic        ctrl_busy = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exec_cnt = 0;
  int          done_cnt = 0;
  int          last_raise = 0;
  logic [7:0]  model_ram [512];
  bit          chk_rd_en = 1'b0;
  bit          rd_vld_q = 1'b0;
  logic [8:0]  rd_addr_q = 9'd0;
  logic [15:0] crc_exp = 16'h0000;

  sd_sector_buffer #(
    .SECTOR_BYTES  (512),
    .ADDR_W        (9),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_read            (req_read),
    .req_write           (req_write),
    .req_sector          (req_sector),
    .host_addr           (host_addr),
    .host_wdata          (host_wdata),
    .host_we             (host_we),
    .host_rdata          (host_rdata),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .crc_out             (crc_out),
    .ctrl_op_code        (ctrl_op_code),
    .ctrl_execute        (ctrl_execute),
    .ctrl_sector_address (ctrl_sector_address),
    .ctrl_outgoing_byte  (ctrl_outgoing_byte),
    .ctrl_incoming_byte  (ctrl_incoming_byte),
    .ctrl_finished_byte  (ctrl_finished_byte),
    .ctrl_finished_sector(ctrl_finished_sector),
    .ctrl_busy           (ctrl_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC16-CCITT (XMODEM flavour) over the first n model bytes.
  function automatic logic [15:0] crc_ref(input logic [7:0] b [512], input int n);
    logic [15:0] c = 16'h0000;
    for (int k = 0; k < n; k++) begin
      c = c ^ {b[k], 8'h00};
      for (int j = 0; j < 8; j++) begin
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] crc_after_done();
`ifdef SD_SECTOR_BUF_CRC16_EN
    return crc_ref(model_ram, 512);
`else
    return 16'h0000;
`endif
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_addr_q <= host_addr;
    rd_vld_q  <= chk_rd_en;
  end

  // Compare process: host read data against the model, plus pulse counters.
  always @(negedge clk) begin
    if (ctrl_execute) exec_cnt = exec_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (rd_vld_q) begin
      chk($sformatf("host_rdata[%0d]", rd_addr_q), {24'd0, host_rdata},
          {24'd0, model_ram[rd_addr_q]});
    end
  end

  task automatic fill_ram(input bit zeros);
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      host_addr    = 9'(i);
      host_wdata   = zeros ? 8'h00 : i[7:0];
      host_we      = 1'b1;
      model_ram[i] = host_wdata;
    end
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic read_range(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      host_addr = 9'(i);
      chk_rd_en = 1'b1;
    end
    @(negedge clk);
    chk_rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic peek(input int a, output logic [7:0] v);
    @(negedge clk);
    host_addr = 9'(a);
    @(negedge clk);
    v = host_rdata;
  endtask

  task automatic req(input bit rd, input bit wr, input logic [25:0] s);
    @(negedge clk);
    req_read   = rd;
    req_write  = wr;
    req_sector = s;
    @(negedge clk);
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  // Behavioural controller: waits for execute, then completes nbytes bytes.
  task automatic ctrl_run(input bit is_write, input int nbytes,
                          input logic [7:0] pat, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ctrl_execute) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_execute_seen"}, {31'd0, seen}, 32'd1);
    ctrl_busy = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      if (is_write) begin
        chk($sformatf("%s_out[%0d]", tag, i), {24'd0, ctrl_outgoing_byte},
            {24'd0, model_ram[i]});
      end
      ctrl_incoming_byte = pat ^ i[7:0];
      if (!is_write) model_ram[i] = pat ^ i[7:0];
      ctrl_finished_byte = 1'b1;
      last_raise = cyc;
      repeat (3) @(negedge clk);
      ctrl_finished_byte = 1'b0;
      repeat (2) @(negedge clk);
    end
    ctrl_busy = 1'b0;
  endtask

  task automatic sector_end(input bit expect_ok, input string tag);
    int d0 = done_cnt;
    bit seen = 1'b0;
    logic busy_next = 1'b1;
    @(negedge clk);
    ctrl_finished_sector = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) ctrl_finished_sector = 1'b0;
      if (!seen && (done || error)) begin
        seen = 1'b1;
        @(negedge clk);
        busy_next = busy;
      end
    end
    ctrl_finished_sector = 1'b0;
    chk({tag, "_end_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_busy_after"}, {31'd0, busy_next}, 32'd0);
    chk({tag, "_done_pulses"}, done_cnt - d0, expect_ok ? 32'd1 : 32'd0);
    chk({tag, "_error"}, {31'd0, error}, expect_ok ? 32'd0 : 32'd1);
  endtask

  initial begin
    int          e0;
    int          t_err;
    int          dt;
    logic [7:0]  v;
    logic [7:0]  pin [512];

    // Model pin: standard check value of the CRC over "123456789".
    pin[0] = 8'h31; pin[1] = 8'h32; pin[2] = 8'h33; pin[3] = 8'h34; pin[4] = 8'h35;
    pin[5] = 8'h36; pin[6] = 8'h37; pin[7] = 8'h38; pin[8] = 8'h39;
    chk("model_crc_pin", {16'd0, crc_ref(pin, 9)}, 32'h31C3);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_execute", {31'd0, ctrl_execute}, 32'd0);
    chk("rst_op_code", {31'd0, ctrl_op_code}, 32'd0);
    chk("rst_sector", {6'd0, ctrl_sector_address}, 32'd0);
    chk("rst_outgoing", {24'd0, ctrl_outgoing_byte}, 32'h00);
    chk("rst_crc", {16'd0, crc_out}, 32'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Write path: RAM[i] = i, sector 5.
    fill_ram(1'b0);
    read_range(0, 512);
    peek(511, v);
    chk("lit_ram_1ff", {24'd0, v}, 32'hFF);
    e0 = exec_cnt;
    req(1'b0, 1'b1, 26'h5);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_op_code", {31'd0, ctrl_op_code}, 32'd1);
    chk("wr_sector", {6'd0, ctrl_sector_address}, 32'h5);
    ctrl_run(1'b1, 512, 8'h00, "wr");
    sector_end(1'b1, "wr");
    chk("wr_exec_pulses", exec_cnt - e0, 32'd1);
    crc_exp = crc_after_done();
    chk("wr_crc", {16'd0, crc_out}, {16'd0, crc_exp});

    // Read path: sector 7, controller returns A5 ^ i.
    e0 = exec_cnt;
    req(1'b1, 1'b0, 26'h7);
    chk("rd_op_code", {31'd0, ctrl_op_code}, 32'd0);
    chk("rd_sector", {6'd0, ctrl_sector_address}, 32'h7);
    ctrl_run(1'b0, 512, 8'hA5, "rd");
    sector_end(1'b1, "rd");
    chk("rd_exec_pulses", exec_cnt - e0, 32'd1);
    crc_exp = crc_after_done();
    chk("rd_crc", {16'd0, crc_out}, {16'd0, crc_exp});
    chk("model_pin_010", {24'd0, model_ram[16]}, 32'hB5);
    peek(16, v);
    chk("lit_ram_010", {24'd0, v}, 32'hB5);
    read_range(0, 512);

    // Short sector: 300 bytes then sector end.
    req(1'b1, 1'b0, 26'h3);
    chk("short_error_cleared", {31'd0, error}, 32'd0);
    ctrl_run(1'b0, 300, 8'h3C, "short");
    sector_end(1'b0, "short");
    repeat (5) @(negedge clk);
    chk("short_error_sticky", {31'd0, error}, 32'd1);
    chk("short_crc_held", {16'd0, crc_out}, {16'd0, crc_exp});

    // Stall after 10 bytes: timeout.
    e0 = done_cnt;
    req(1'b1, 1'b0, 26'h9);
    chk("tmo_error_cleared", {31'd0, error}, 32'd0);
    ctrl_run(1'b0, 10, 8'h5A, "tmo");
    t_err = -1;
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge clk);
      if (error) begin
        t_err = cyc;
        break;
      end
    end
    chk("tmo_error_seen", {31'd0, t_err >= 0}, 32'd1);
    dt = t_err - last_raise;
    chk($sformatf("tmo_delay_%0d_in_window", dt),
        {31'd0, (dt >= TMO && dt <= TMO + 4)}, 32'd1);
    @(negedge clk);
    chk("tmo_busy_after", {31'd0, busy}, 32'd0);
    chk("tmo_no_done", done_cnt - e0, 32'd0);
    read_range(0, 16);

    // Simultaneous requests take the write; reset after 100 bytes.
    req(1'b1, 1'b1, 26'h1F);
    chk("both_op_code", {31'd0, ctrl_op_code}, 32'd1);
    chk("both_sector", {6'd0, ctrl_sector_address}, 32'h1F);
    ctrl_run(1'b1, 100, 8'h00, "both");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_error", {31'd0, error}, 32'd0);
    chk("mid_rst_execute", {31'd0, ctrl_execute}, 32'd0);
    chk("mid_rst_op_code", {31'd0, ctrl_op_code}, 32'd0);
    chk("mid_rst_sector", {6'd0, ctrl_sector_address}, 32'd0);
    chk("mid_rst_outgoing", {24'd0, ctrl_outgoing_byte}, 32'h00);
    chk("mid_rst_crc", {16'd0, crc_out}, 32'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    read_range(0, 32);

    // All-zero sector.
    fill_ram(1'b1);
    req(1'b0, 1'b1, 26'h20);
    ctrl_run(1'b1, 512, 8'h00, "zero");
    sector_end(1'b1, "zero");
    chk("zero_crc", {16'd0, crc_out}, 32'h0000);

    // 0x31 followed by zeros.
    @(negedge clk);
    host_addr    = 9'd0;
    host_wdata   = 8'h31;
    host_we      = 1'b1;
    model_ram[0] = 8'h31;
    @(negedge clk);
    host_we = 1'b0;
    req(1'b0, 1'b1, 26'h21);
    ctrl_run(1'b1, 512, 8'h00, "one");
    sector_end(1'b1, "one");
    crc_exp = crc_after_done();
    chk("one_crc", {16'd0, crc_out}, {16'd0, crc_exp});

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
